// File: rtl/bpu_pkg.sv
// Shared branch-predictor definitions: predictor FSM states, default counter
// width and the saturating-counter step used by every PHT.
package bpu_pkg;

    localparam int BPU_CTR_WIDTH = 2;

    typedef enum logic {
        INIT,
        READY
    } bimodal_state_e;

    // Width-generic saturating step; callers truncate the result to their counter width.
    function automatic logic [31:0] sat_ctr_next(
        input logic [31:0] ctr,
        input logic        taken,
        input int          width
    );
        logic [31:0] max_val;
        max_val = (32'd1 << width) - 32'd1;
        if (taken) begin
            return (ctr >= max_val) ? max_val : ctr + 32'd1;
        end
        return (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
    endfunction

endpackage

// File: rtl/bimodal_bank.sv
// One PHT bank: ROWS saturating counters, a registered read port and a
// write port that either stores the init value or applies a counter step.
module bimodal_bank
    import bpu_pkg::*;
#(
    parameter int                   ROW_W     = 8,
    parameter int                   CTR_WIDTH = BPU_CTR_WIDTH,
    parameter logic [CTR_WIDTH-1:0] INIT_CTR  = CTR_WIDTH'(1) << (CTR_WIDTH - 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_rd_en,
    input  logic [ROW_W-1:0]     i_rd_row,
    output logic [CTR_WIDTH-1:0] o_rd_ctr,
    input  logic                 i_wr_en,
    input  logic                 i_wr_init,
    input  logic [ROW_W-1:0]     i_wr_row,
    input  logic                 i_wr_taken
);

    localparam int ROWS = 1 << ROW_W;

    logic [CTR_WIDTH-1:0] r_mem [ROWS];
    logic [CTR_WIDTH-1:0] r_rd_ctr;
    logic [CTR_WIDTH-1:0] w_wr_data;

    // NOTE: every always_comb output gets its value on every path, so no latch is inferred.
    always_comb begin
        if (i_wr_init) begin
            w_wr_data = INIT_CTR;
        end else begin
            w_wr_data = CTR_WIDTH'(sat_ctr_next(32'(r_mem[i_wr_row]), i_wr_taken, CTR_WIDTH));
        end
    end

    // NOTE: the table has no reset branch; the FSM's init sweep gives it defined contents.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_row] <= w_wr_data;
        end
    end

    // A same-cycle write to i_rd_row is not forwarded: the read sees the old counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ctr <= '0;
        end else if (i_rd_en) begin
            r_rd_ctr <= r_mem[i_rd_row];
        end
    end

    assign o_rd_ctr = r_rd_ctr;

endmodule

// File: rtl/bimodal_predictor.sv
// Multi-slot bimodal predictor: FETCH_WIDTH banked PHT, 1-cycle query latency,
// single-bank commit-time updates, self-timed init sweep after reset.
module bimodal_predictor
    import bpu_pkg::*;
#(
    parameter int                   TABLE_DEPTH_EXP2 = 10,
    parameter int                   CTR_WIDTH        = BPU_CTR_WIDTH,
    parameter int                   PC_WIDTH         = 32,
    parameter int                   FETCH_WIDTH      = 4,
    parameter logic [CTR_WIDTH-1:0] INIT_CTR         = CTR_WIDTH'(1) << (CTR_WIDTH - 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic                             ready_o,
    input  logic                             query_valid_i,
    input  logic [PC_WIDTH-1:0]              query_pc_i,
    output logic                             query_valid_o,
    output logic [FETCH_WIDTH-1:0]           query_taken_o,
    output logic [FETCH_WIDTH*CTR_WIDTH-1:0] query_ctr_o,
    input  logic                             update_valid_i,
    input  logic [PC_WIDTH-1:0]              update_pc_i,
    input  logic                             update_taken_i
);

    localparam int BANK_BITS = $clog2(FETCH_WIDTH);
    localparam int ROW_BITS  = TABLE_DEPTH_EXP2 - BANK_BITS;
    localparam int BANK_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int ROW_W     = (ROW_BITS > 0) ? ROW_BITS : 1;
    localparam int ROWS      = 1 << ROW_BITS;

    bimodal_state_e         r_state;
    logic [ROW_W-1:0]       r_sweep_row;
    logic                   r_ready;
    logic                   r_query_valid;

    logic [ROW_W-1:0]       w_query_row;
    logic [ROW_W-1:0]       w_upd_row;
    logic [BANK_W-1:0]      w_upd_bank;
    logic [ROW_W-1:0]       w_wr_row;
    logic                   w_wr_init;
    logic [FETCH_WIDTH-1:0] w_wr_en;
    logic                   w_rd_en;
    logic [CTR_WIDTH-1:0]   w_bank_ctr [FETCH_WIDTH];
    logic                   w_unused;

    if (ROW_BITS > 0) begin : g_row
        assign w_query_row = query_pc_i[2+BANK_BITS +: ROW_W];
        assign w_upd_row   = update_pc_i[2+BANK_BITS +: ROW_W];
    end else begin : g_no_row
        assign w_query_row = '0;
        assign w_upd_row   = '0;
    end

    if (BANK_BITS > 0) begin : g_bank_sel
        assign w_upd_bank = update_pc_i[2 +: BANK_W];
    end else begin : g_no_bank_sel
        assign w_upd_bank = '0;
    end

    // Only the index bits of the PCs matter to this table.
    assign w_unused = ^{query_pc_i, update_pc_i};

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= INIT;
            r_sweep_row   <= '0;
            r_ready       <= 1'b0;
            r_query_valid <= 1'b0;
        end else begin
            r_query_valid <= w_rd_en;
            case (r_state)
                INIT: begin
                    r_sweep_row <= r_sweep_row + 1'b1;
                    if (r_sweep_row == ROW_W'(ROWS - 1)) begin
                        r_state <= READY;
                        r_ready <= 1'b1;
                    end
                end
                READY: begin
                    r_state <= READY;
                end
                default: begin
                    r_state <= INIT;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // Sweep owns every bank's write port until READY; a reset cycle writes nothing.
    always_comb begin
        w_wr_row  = w_upd_row;
        w_wr_init = 1'b0;
        w_wr_en   = '0;
        if (!rst) begin
            if (r_state == INIT) begin
                w_wr_row  = r_sweep_row;
                w_wr_init = 1'b1;
                w_wr_en   = '1;
            end else if (update_valid_i) begin
                w_wr_en = FETCH_WIDTH'(1) << w_upd_bank;
            end
        end
    end

    assign w_rd_en = !rst && (r_state == READY) && query_valid_i;

    for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_banks
        bimodal_bank #(
            .ROW_W     (ROW_W),
            .CTR_WIDTH (CTR_WIDTH),
            .INIT_CTR  (INIT_CTR)
        ) u_bank (
            .clk        (clk),
            .rst        (rst),
            .i_rd_en    (w_rd_en),
            .i_rd_row   (w_query_row),
            .o_rd_ctr   (w_bank_ctr[g]),
            .i_wr_en    (w_wr_en[g]),
            .i_wr_init  (w_wr_init),
            .i_wr_row   (w_wr_row),
            .i_wr_taken (update_taken_i)
        );

        assign query_taken_o[g]                        = w_bank_ctr[g][CTR_WIDTH-1];
        assign query_ctr_o[g*CTR_WIDTH +: CTR_WIDTH]   = w_bank_ctr[g];
    end

    assign ready_o       = r_ready;
    assign query_valid_o = r_query_valid;

endmodule

// File: tb/tb_bimodal_predictor.sv
// Self-checking bench for bimodal_predictor with default parameters: a flat
// counter-table model checked every cycle, plus hand-computed literal checks.
module tb_bimodal_predictor;

    localparam int ENTRIES   = 1024;
    localparam int INIT_LEN  = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready_o;
    logic        query_valid_i;
    logic [31:0] query_pc_i;
    logic        query_valid_o;
    logic [3:0]  query_taken_o;
    logic [7:0]  query_ctr_o;
    logic        update_valid_i;
    logic [31:0] update_pc_i;
    logic        update_taken_i;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    bimodal_predictor dut (
        .clk            (clk),
        .rst            (rst),
        .ready_o        (ready_o),
        .query_valid_i  (query_valid_i),
        .query_pc_i     (query_pc_i),
        .query_valid_o  (query_valid_o),
        .query_taken_o  (query_taken_o),
        .query_ctr_o    (query_ctr_o),
        .update_valid_i (update_valid_i),
        .update_pc_i    (update_pc_i),
        .update_taken_i (update_taken_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a flat table of 1024 counters indexed by pc[11:2]; init is one
    // 256-cycle delay after which every counter is 2.
    int m_tab [ENTRIES];
    int m_init_cnt;
    bit m_ready;
    bit exp_qv;
    int exp_ctr [4];

    always @(posedge clk) begin
        if (rst) begin
            m_init_cnt = 0;
            m_ready    = 1'b0;
            exp_qv     = 1'b0;
            for (int s = 0; s < 4; s++) exp_ctr[s] = 0;
        end else if (!m_ready) begin
            exp_qv = 1'b0;
            m_init_cnt++;
            if (m_init_cnt == INIT_LEN) begin
                m_ready = 1'b1;
                for (int e = 0; e < ENTRIES; e++) m_tab[e] = 2;
            end
        end else begin
            exp_qv = query_valid_i;
            if (query_valid_i) begin
                for (int s = 0; s < 4; s++) exp_ctr[s] = m_tab[int'(query_pc_i[11:4]) * 4 + s];
            end
            if (update_valid_i) begin
                int idx;
                idx = int'(update_pc_i[11:2]);
                if (update_taken_i) m_tab[idx] = (m_tab[idx] == 3) ? 3 : m_tab[idx] + 1;
                else                m_tab[idx] = (m_tab[idx] == 0) ? 0 : m_tab[idx] - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [7:0] exp_vec;
            logic [3:0] exp_tk;
            for (int s = 0; s < 4; s++) begin
                exp_vec[s*2 +: 2] = exp_ctr[s][1:0];
                exp_tk[s]         = (exp_ctr[s] >= 2);
            end
            check("ready_o", 32'(ready_o), 32'(m_ready));
            check("query_valid_o", 32'(query_valid_o), 32'(exp_qv));
            check("query_ctr_o", 32'(query_ctr_o), 32'(exp_vec));
            check("query_taken_o", 32'(query_taken_o), 32'(exp_tk));
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_query(input logic [31:0] pc);
        query_valid_i = 1'b1;
        query_pc_i    = pc;
        cycle();
        query_valid_i = 1'b0;
    endtask

    task automatic do_update(input logic [31:0] pc, input logic taken);
        update_valid_i = 1'b1;
        update_pc_i    = pc;
        update_taken_i = taken;
        cycle();
        update_valid_i = 1'b0;
    endtask

    // Counts cycles with ready_o low, starting right after rst is released.
    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (n < 400) begin
            @(negedge clk);
            if (ready_o) break;
            n++;
        end
        check(name, 32'(n), 32'(INIT_LEN));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        query_valid_i  = 1'b0;
        query_pc_i     = '0;
        update_valid_i = 1'b0;
        update_pc_i    = '0;
        update_taken_i = 1'b0;
        repeat (3) cycle();
        cmp_en = 1'b1;
        check("reset_ready", 32'(ready_o), 32'd0);
        check("reset_ctr", 32'(query_ctr_o), 32'd0);
        rst = 1'b0;

        wait_ready("init_cycles");
        do_query(32'h1C000000);
        check("init_taken", 32'(query_taken_o), 32'hF);
        check("init_ctr", 32'(query_ctr_o), 32'hAA);

        repeat (3) do_update(32'h1C000008, 1'b1);
        do_query(32'h1C000000);
        check("sat_hi_taken", 32'(query_taken_o), 32'hF);
        check("sat_hi_ctr", 32'(query_ctr_o), 32'hBA);

        do_update(32'h1C00001C, 1'b0);
        do_query(32'h1C00001C);
        check("dec1_ctr", 32'(query_ctr_o), 32'h6A);
        check("dec1_taken", 32'(query_taken_o), 32'h7);
        do_update(32'h1C00001C, 1'b0);
        do_query(32'h1C00001C);
        check("dec2_ctr", 32'(query_ctr_o), 32'h2A);
        do_update(32'h1C00001C, 1'b0);
        do_query(32'h1C00001C);
        check("sat_lo_ctr", 32'(query_ctr_o), 32'h2A);

        update_valid_i = 1'b1;
        update_pc_i    = 32'h1C000000;
        update_taken_i = 1'b1;
        do_query(32'h1C000000);
        update_valid_i = 1'b0;
        check("collide_old", 32'(query_ctr_o), 32'hBA);
        do_query(32'h1C000000);
        check("collide_new", 32'(query_ctr_o), 32'hBB);

        for (int i = 0; i < 24; i++) begin
            update_valid_i = 1'b1;
            update_pc_i    = 32'h1C000000 + 32'((i * 52) & 32'hFC);
            update_taken_i = i[0] ^ i[2];
            query_valid_i  = (i % 3) != 2;
            query_pc_i     = 32'h1C000000 + 32'((i * 20) & 32'hF0);
            cycle();
        end
        update_valid_i = 1'b0;
        query_valid_i  = 1'b0;

        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("rst_ready_drop", 32'(ready_o), 32'd0);
        for (int i = 0; i < 100; i++) begin
            update_valid_i = 1'b1;
            update_pc_i    = 32'h1C000000;
            update_taken_i = 1'b0;
            query_valid_i  = 1'b1;
            query_pc_i     = 32'h1C000010;
            cycle();
        end
        update_valid_i = 1'b0;
        query_valid_i  = 1'b0;
        check("init_qv", 32'(query_valid_o), 32'd0);

        rst = 1'b1;
        cycle();
        rst = 1'b0;
        wait_ready("resweep_cycles");
        do_query(32'h1C000000);
        check("resweep_row0", 32'(query_ctr_o), 32'hAA);
        do_query(32'h1C000010);
        check("resweep_row1", 32'(query_ctr_o), 32'hAA);
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
